// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES definitions: word/byte widths, typedefs and GF(2^8) helpers.
// The helpers are kept here so InvMixColumns and the key schedule can reuse
// them without duplicating the field arithmetic.
// Ports: none (package).
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam int WORD_DATA_WIDTH = 32;
  localparam int BYTE_WIDTH      = 8;

  typedef logic [BYTE_WIDTH-1:0]      byte_t;
  typedef logic [WORD_DATA_WIDTH-1:0] word_t;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1 (0x11B). Reducing with
  // 0x1B accounts for the dropped x^8 term when the top bit shifts out.
  function automatic byte_t xtime(input byte_t b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic byte_t gf_mul2(input byte_t b);
    gf_mul2 = xtime(b);
  endfunction

  function automatic byte_t gf_mul3(input byte_t b);
    gf_mul3 = xtime(b) ^ b;
  endfunction

endpackage

// File: rtl/aes_mix_columns_if.sv
// ---------------------------------------------------------------------------
// aes_mix_columns_if
// Column stream between SubBytes, the MixColumns stage and AddRoundKey.
// Signals:
//   word_in_comb_sub_bytes       input column, s0 in [31:24] .. s3 in [7:0]
//   word_in_comb_sub_bytes_vld   input column valid
//   mix_column_off               1 = bypass (final round), 0 = MixColumns
//   word_out_comb_mix_column     registered result column
//   word_out_comb_mix_column_vld result valid
// Modports:
//   master  upstream/downstream datapath side (drives the input column)
//   slave   the MixColumns stage itself
// ---------------------------------------------------------------------------
interface aes_mix_columns_if;
  import aes_pkg::*;

  word_t word_in_comb_sub_bytes;
  logic  word_in_comb_sub_bytes_vld;
  logic  mix_column_off;
  word_t word_out_comb_mix_column;
  logic  word_out_comb_mix_column_vld;

  modport master (
    output word_in_comb_sub_bytes,
    output word_in_comb_sub_bytes_vld,
    output mix_column_off,
    input  word_out_comb_mix_column,
    input  word_out_comb_mix_column_vld
  );

  modport slave (
    input  word_in_comb_sub_bytes,
    input  word_in_comb_sub_bytes_vld,
    input  mix_column_off,
    output word_out_comb_mix_column,
    output word_out_comb_mix_column_vld
  );

endinterface

// File: rtl/aes_mix_single_column.sv
// ---------------------------------------------------------------------------
// aes_mix_single_column
// Purely combinational MixColumns transform of one 32-bit state column.
// Ports:
//   column_in   input column  {s0,s1,s2,s3}
//   column_out  mixed column  {r0,r1,r2,r3}, same byte order
// ---------------------------------------------------------------------------
module aes_mix_single_column
  import aes_pkg::*;
(
  input  word_t column_in,
  output word_t column_out
);

  byte_t s0, s1, s2, s3;
  byte_t r0, r1, r2, r3;

  assign s0 = column_in[31:24];
  assign s1 = column_in[23:16];
  assign s2 = column_in[15:8];
  assign s3 = column_in[7:0];

  // Rows of the circulant matrix {02 03 01 01} applied to the column.
  assign r0 = gf_mul2(s0) ^ gf_mul3(s1) ^ s2          ^ s3;
  assign r1 = s0          ^ gf_mul2(s1) ^ gf_mul3(s2) ^ s3;
  assign r2 = s0          ^ s1          ^ gf_mul2(s2) ^ gf_mul3(s3);
  assign r3 = gf_mul3(s0) ^ s1          ^ s2          ^ gf_mul2(s3);

  assign column_out = {r0, r1, r2, r3};

endmodule

// File: rtl/aes_mix_columns.sv
// ---------------------------------------------------------------------------
// aes_mix_columns
// Registered AES MixColumns stage, one column per cycle, 1-cycle latency,
// no backpressure. A bypass control passes the column through untouched for
// the final round.
// Ports:
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset; clears data and valid at once
//   bus      aes_mix_columns_if.slave column stream (see interface header)
// ---------------------------------------------------------------------------
module aes_mix_columns
  import aes_pkg::*;
(
  input logic             clock,
  input logic             reset_n,
  aes_mix_columns_if.slave bus
);

  word_t mixed_word;
  word_t next_word;
  word_t data_q;
  logic  vld_q;

  aes_mix_single_column u_mix (
    .column_in  (bus.word_in_comb_sub_bytes),
    .column_out (mixed_word)
  );

  // The bypass select travels with its column, so it is taken from the same
  // cycle as the data rather than being registered separately.
  assign next_word = bus.mix_column_off ? bus.word_in_comb_sub_bytes : mixed_word;

  // Data only loads on a valid column, so don't-care input data during gaps
  // can never reach the output; valid simply follows the input one cycle late.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= bus.word_in_comb_sub_bytes_vld;
      if (bus.word_in_comb_sub_bytes_vld) begin
        data_q <= next_word;
      end
    end
  end

  assign bus.word_out_comb_mix_column     = data_q;
  assign bus.word_out_comb_mix_column_vld = vld_q;

endmodule

// File: tb/tb_aes_mix_columns.sv
// ---------------------------------------------------------------------------
// tb_aes_mix_columns
// Directed-vector bench for aes_mix_columns with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_aes_mix_columns;
  import aes_pkg::*;

  logic clock;
  logic reset_n;

  int assertCount = 0;
  int failCount   = 0;

  aes_mix_columns_if bus ();

  aes_mix_columns dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Guard against a stuck run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one observed value with its expected value and count it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %08h, expected %08h", tag, observed, expected);
    end
  endtask

  // Drive one column at the falling edge, then step past the next rising edge.
  task automatic applyStimulus(input word_t data, input logic vld, input logic off);
    @(negedge clock);
    bus.word_in_comb_sub_bytes     = data;
    bus.word_in_comb_sub_bytes_vld = vld;
    bus.mix_column_off             = off;
    @(posedge clock);
    #1;
  endtask

  task automatic checkWord(input string tag, input word_t expData, input logic expVld);
    checkOutput({tag, "_data"}, bus.word_out_comb_mix_column, expData);
    checkOutput({tag, "_vld"}, {31'b0, bus.word_out_comb_mix_column_vld}, {31'b0, expVld});
  endtask

  typedef struct {
    word_t din;
    logic  off;
    word_t dout;
  } vec_t;

  vec_t streamVecs[10] = '{
    '{32'hdb135345, 1'b0, 32'h8e4da1bc},
    '{32'hf20a225c, 1'b0, 32'h9fdc589d},
    '{32'h2d26314c, 1'b0, 32'h4d7ebdf8},
    '{32'hd4d4d4d5, 1'b0, 32'hd5d5d7d6},
    '{32'h01010101, 1'b0, 32'h01010101},
    '{32'hc6c6c6c6, 1'b0, 32'hc6c6c6c6},
    '{32'hdb135345, 1'b1, 32'hdb135345},
    '{32'hdb135345, 1'b0, 32'h8e4da1bc},
    '{32'hdb135345, 1'b1, 32'hdb135345},
    '{32'h80808080, 1'b0, 32'h80808080}
  };

  initial begin
    bus.word_in_comb_sub_bytes     = '0;
    bus.word_in_comb_sub_bytes_vld = 1'b0;
    bus.mix_column_off             = 1'b0;
    reset_n = 1'b0;
    #12;
    checkWord("reset", 32'h0, 1'b0);

    @(negedge clock);
    reset_n = 1'b1;

    // Back-to-back stream: each result must appear right after its edge.
    foreach (streamVecs[i]) begin
      applyStimulus(streamVecs[i].din, 1'b1, streamVecs[i].off);
      checkWord($sformatf("stream%0d", i), streamVecs[i].dout, 1'b1);
    end

    applyStimulus(32'h80000000, 1'b1, 1'b0);
    checkWord("reduce80", 32'h1b80809b, 1'b1);

    // Valid gaps 1,0,0,1: data holds the last result while junk is driven.
    applyStimulus(32'hf20a225c, 1'b1, 1'b0);
    checkWord("gap_v1", 32'h9fdc589d, 1'b1);
    applyStimulus(32'h12345678, 1'b0, 1'b0);
    checkWord("gap_v0a", 32'h9fdc589d, 1'b0);
    applyStimulus(32'hdeadbeef, 1'b0, 1'b1);
    checkWord("gap_v0b", 32'h9fdc589d, 1'b0);
    applyStimulus(32'h2d26314c, 1'b1, 1'b0);
    checkWord("gap_v1b", 32'h4d7ebdf8, 1'b1);
    applyStimulus(32'h0, 1'b0, 1'b0);
    checkWord("gap_tail", 32'h4d7ebdf8, 1'b0);

    // Mid-stream reset with valid high: outputs clear without a clock edge.
    applyStimulus(32'hdb135345, 1'b1, 1'b0);
    checkWord("pre_rst", 32'h8e4da1bc, 1'b1);
    reset_n = 1'b0;
    #1;
    checkWord("mid_rst", 32'h0, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    checkWord("post_rst_idle", 32'h0, 1'b0);
    applyStimulus(32'hd4d4d4d5, 1'b1, 1'b0);
    checkWord("post_rst_first", 32'hd5d5d7d6, 1'b1);
    applyStimulus(32'h0, 1'b0, 1'b0);
    checkWord("post_rst_drop", 32'hd5d5d7d6, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
